// File: rtl/if_id_fetch_queue_pkg.sv
// Shared pipeline definitions for the IF/ID fetch queue.
package if_id_fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One buffered fetch: instruction word plus the PC+4 that goes with it.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pci;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port so the head entry is visible without a read cycle.
module fetch_queue_mem
    import if_id_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic               Clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  fetch_entry_t       wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output fetch_entry_t       rd_data
);

    fetch_entry_t mem [DEPTH];

    // Storage is not reset; the count in the parent decides what is valid.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// In-order queue between fetch and decode. Accepts {instr, PC+4} from IF,
// presents the head to ID with valid/ready, and drops everything on a flush.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int                 DEPTH  = 4,
    parameter int                 ADDR_W = 2,
    parameter logic [INSTR_W-1:0] NOP    = NOP_INSTR
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               In_Valid,
    input  logic [INSTR_W-1:0] In_Instr,
    input  logic [PC_W-1:0]    In_PCI,
    output logic               In_Ready,
    output logic               Out_Valid,
    output logic [INSTR_W-1:0] Out_Instr,
    output logic [PC_W-1:0]    Out_PCI,
    input  logic               Out_Ready,
    input  logic               Flush,
    output logic [ADDR_W:0]    Count,
    output logic               Ovf
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              ovf_q;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      rd_entry;

    // Handshake flags come only from the registered count, so Out_Ready never
    // reaches In_Ready combinationally; a full queue refuses a push even while
    // it is being popped.
    always_comb begin
        In_Ready  = (count != FULL_CNT);
        Out_Valid = (count != '0);
        push      = In_Valid & In_Ready & ~Flush;
        pop       = Out_Valid & Out_Ready & ~Flush;
    end

    // Pointer/count update; flush wins over push and pop, pointers wrap naturally.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Dropped-push indicator, one cycle after IF offered a word to a full queue.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= In_Valid & ~In_Ready & ~Flush;
        end
    end

    assign wr_entry.instr = In_Instr;
    assign wr_entry.pci   = In_PCI;

    fetch_queue_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .Clk     (Clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // Show-ahead head; empty queue presents a NOP with a zero PC+4.
    always_comb begin
        Out_Instr = NOP;
        Out_PCI   = '0;
        if (Out_Valid) begin
            Out_Instr = rd_entry.instr;
            Out_PCI   = rd_entry.pci;
        end
    end

    assign Count = count;
    assign Ovf   = ovf_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Scoreboard bench for if_id_fetch_queue: stimulus queues the expected
// entries, a negedge monitor compares every head consumed by ID.
module tb_if_id_fetch_queue;

    logic        Clk;
    logic        Rst;
    logic        In_Valid;
    logic [31:0] In_Instr;
    logic [31:0] In_PCI;
    logic        In_Ready;
    logic        Out_Valid;
    logic [31:0] Out_Instr;
    logic [31:0] Out_PCI;
    logic        Out_Ready;
    logic        Flush;
    logic [2:0]  Count;
    logic        Ovf;

    int passed = 0;
    int total  = 0;
    int pops   = 0;

    logic [63:0] exp_q[$];

    if_id_fetch_queue dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Instr  (In_Instr),
        .In_PCI    (In_PCI),
        .In_Ready  (In_Ready),
        .Out_Valid (Out_Valid),
        .Out_Instr (Out_Instr),
        .Out_PCI   (Out_PCI),
        .Out_Ready (Out_Ready),
        .Flush     (Flush),
        .Count     (Count),
        .Ovf       (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pci,
                         input logic ordy, input logic fl);
        In_Valid  = v;
        In_Instr  = instr;
        In_PCI    = pci;
        Out_Ready = ordy;
        Flush     = fl;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue a push that the queue is known to accept and record its expected value.
    task automatic push_one(input logic [31:0] instr, input logic [31:0] pci, input logic ordy);
        drive(1'b1, instr, pci, ordy, 1'b0);
        exp_q.push_back({instr, pci});
        step();
    endtask

    // Monitor: whatever ID consumes at the coming edge must be the oldest expected entry.
    always @(negedge Clk) begin
        if (Rst && Out_Valid && Out_Ready && !Flush) begin
            pops++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_pop: got instr 0x%08h pci 0x%08h expected nothing", Out_Instr, Out_PCI);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("pop_instr", Out_Instr, e[63:32]);
                check("pop_pci", Out_PCI, e[31:0]);
            end
        end
    end

    initial begin
        Rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        check("rst_count", 32'(Count), 32'd0);
        check("rst_out_valid", 32'(Out_Valid), 32'd0);
        check("rst_out_instr", Out_Instr, 32'h0);
        check("rst_out_pci", Out_PCI, 32'h0);
        check("rst_in_ready", 32'(In_Ready), 32'd1);
        check("rst_ovf", 32'(Ovf), 32'd0);
        Rst = 1'b1;
        step();

        // Fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            push_one(32'h2008_0005, 32'(4 * (i + 1)), 1'b0);
            check("fill_count", 32'(Count), 32'(i + 1));
        end
        check("full_in_ready", 32'(In_Ready), 32'd0);
        check("full_ovf_before", 32'(Ovf), 32'd0);
        drive(1'b1, 32'h2009_000A, 32'd20, 1'b0, 1'b0);
        step();
        check("ovf_pulse", 32'(Ovf), 32'd1);
        check("ovf_count", 32'(Count), 32'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check("ovf_clear", 32'(Ovf), 32'd0);
        check("head_instr", Out_Instr, 32'h2008_0005);
        check("head_pci", Out_PCI, 32'd4);

        // Drain in order
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("drain_valid", 32'(Out_Valid), 32'd0);
        check("drain_instr", Out_Instr, 32'h0);
        check("drain_pci", Out_PCI, 32'h0);
        check("drain_in_ready", 32'(In_Ready), 32'd1);

        // Simultaneous push and pop at count 2, pointers wrap several times
        push_one(32'h1111_0000, 32'h100, 1'b0);
        push_one(32'h1111_0001, 32'h104, 1'b0);
        check("sim_start_count", 32'(Count), 32'd2);
        for (int k = 2; k < 12; k++) begin
            push_one(32'h1111_0000 + 32'(k), 32'h100 + 32'(4 * k), 1'b1);
            check("sim_count", 32'(Count), 32'd2);
            check("sim_ovf", 32'(Ovf), 32'd0);
        end

        // Flush with concurrent push and pop
        push_one(32'h3333_0000, 32'h200, 1'b0);
        check("pre_flush_count", 32'(Count), 32'd3);
        drive(1'b1, 32'hDEAD_BEEF, 32'h999, 1'b1, 1'b1);
        exp_q.delete();
        step();
        check("flush_count", 32'(Count), 32'd0);
        check("flush_valid", 32'(Out_Valid), 32'd0);
        check("flush_ovf", 32'(Ovf), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check("post_flush_valid", 32'(Out_Valid), 32'd0);

        // Push into empty: no same-cycle bypass
        drive(1'b1, 32'h2222_0000, 32'h40, 1'b0, 1'b0);
        exp_q.push_back({32'h2222_0000, 32'h40});
        #1;
        check("empty_push_no_bypass", 32'(Out_Valid), 32'd0);
        step();
        check("empty_push_valid", 32'(Out_Valid), 32'd1);
        check("empty_push_pci", Out_PCI, 32'h40);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("empty_push_drained", 32'(Count), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset mid-run while overflowing
        for (int i = 0; i < 4; i++) push_one(32'h4444_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0);
        drive(1'b1, 32'h5555_0000, 32'h400, 1'b0, 1'b0);
        step();
        check("pre_rst_ovf", 32'(Ovf), 32'd1);
        Rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_count", 32'(Count), 32'd0);
        check("async_rst_valid", 32'(Out_Valid), 32'd0);
        check("async_rst_instr", Out_Instr, 32'h0);
        check("async_rst_in_ready", 32'(In_Ready), 32'd1);
        check("async_rst_ovf", 32'(Ovf), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        Rst = 1'b1;
        step();
        check("rst_release_ovf", 32'(Ovf), 32'd0);
        check("rst_release_count", 32'(Count), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("total_pops", 32'(pops), 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
